// File: rtl/axi_write_arbiter.sv
// Write-path arbiter for four AXI masters: holds one registered one-hot grant
// per complete AW/W/B transaction, round-robin or fixed priority, with a stall watchdog.
module axi_write_arbiter #(
  parameter int RR_EN          = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       m0_AWVALID,
  input  logic       m1_AWVALID,
  input  logic       m2_AWVALID,
  input  logic       m3_AWVALID,
  input  logic       s_AWVALID,
  input  logic       m_AWREADY,
  input  logic       s_WVALID,
  input  logic       s_WLAST,
  input  logic       m_WREADY,
  input  logic       m_BVALID,
  input  logic       s_BREADY,
  output logic       m0_wgrnt,
  output logic       m1_wgrnt,
  output logic       m2_wgrnt,
  output logic       m3_wgrnt,
  output logic       wbusy,
  output logic [1:0] grant_idx,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t               state_q, state_d;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           ptr_q, ptr_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [3:0] req;
  logic       aw_hs, w_hs, wl_hs, b_hs, any_hs, expire;
  logic       win_vld;
  logic [1:0] win_idx, cand;

  assign req    = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
  assign aw_hs  = s_AWVALID & m_AWREADY;
  assign w_hs   = s_WVALID & m_WREADY;
  assign wl_hs  = w_hs & s_WLAST;
  assign b_hs   = m_BVALID & s_BREADY;
  assign any_hs = aw_hs | w_hs | b_hs;

  // Any handshake in the limit cycle counts as progress, so b_hs always beats expiry.
  assign expire = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && (cnt_q == TO_LIM) && !any_hs;

  // Candidates are scanned from lowest to highest priority so the last hit wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    if (RR_EN != 0) begin
      for (int k = 4; k >= 1; k--) begin
        cand = ptr_q + 2'(k);
        if (req[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (req[k]) begin
          win_vld = 1'b1;
          win_idx = 2'(k);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;

    if (state_q != IDLE) begin
      if (any_hs)
        cnt_d = '0;
      else if (cnt_q != '1)
        cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d   = 4'b0001 << win_idx;
          idx_d     = win_idx;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = XFER;
        end
      end
      XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | wl_hs;
        if ((aw_done_q | aw_hs) && (w_done_q | wl_hs))
          state_d = RESP;
      end
      RESP: begin
        if (b_hs) begin
          grant_d   = 4'b0000;
          ptr_d     = idx_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abandon the stalled transaction; the offender goes to the back of the rotation.
    if (expire) begin
      grant_d   = 4'b0000;
      ptr_d     = idx_q;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd3;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m0_wgrnt    = grant_q[0];
  assign m1_wgrnt    = grant_q[1];
  assign m2_wgrnt    = grant_q[2];
  assign m3_wgrnt    = grant_q[3];
  assign wbusy       = |grant_q;
  assign grant_idx   = idx_q;
  assign timeout_err = expire;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected grant/drop/timeout events with cycle stamps,
// a negedge monitor pops and compares them for a round-robin and a fixed-priority instance.
module tb_axi_write_arbiter;

  localparam int K_GRANT = 0;
  localparam int K_DROP  = 1;
  localparam int K_TO    = 2;

  typedef struct {
    int dut;
    int kind;
    int idx;
    int cyc;
  } ev_t;

  ev_t expq[$];

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [3:0] req_rr = 4'b0, req_fp = 4'b0;
  logic       awv = 1'b0, awr = 1'b0, wv = 1'b0, wl = 1'b0, wr = 1'b0, bv = 1'b0, br = 1'b0;
  logic       done = 1'b0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  logic [3:0] g_rr, g_fp;
  logic       bz_rr, bz_fp, to_rr, to_fp;
  logic [1:0] gi_rr, gi_fp;
  logic [3:0] pg_rr = 4'b0, pg_fp = 4'b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axi_write_arbiter #(.RR_EN(1), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut_rr (
    .ACLK(aclk), .ARESET(areset),
    .m0_AWVALID(req_rr[0]), .m1_AWVALID(req_rr[1]), .m2_AWVALID(req_rr[2]), .m3_AWVALID(req_rr[3]),
    .s_AWVALID(awv), .m_AWREADY(awr), .s_WVALID(wv), .s_WLAST(wl), .m_WREADY(wr),
    .m_BVALID(bv), .s_BREADY(br),
    .m0_wgrnt(g_rr[0]), .m1_wgrnt(g_rr[1]), .m2_wgrnt(g_rr[2]), .m3_wgrnt(g_rr[3]),
    .wbusy(bz_rr), .grant_idx(gi_rr), .timeout_err(to_rr)
  );

  axi_write_arbiter #(.RR_EN(0), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut_fp (
    .ACLK(aclk), .ARESET(areset),
    .m0_AWVALID(req_fp[0]), .m1_AWVALID(req_fp[1]), .m2_AWVALID(req_fp[2]), .m3_AWVALID(req_fp[3]),
    .s_AWVALID(awv), .m_AWREADY(awr), .s_WVALID(wv), .s_WLAST(wl), .m_WREADY(wr),
    .m_BVALID(bv), .s_BREADY(br),
    .m0_wgrnt(g_fp[0]), .m1_wgrnt(g_fp[1]), .m2_wgrnt(g_fp[2]), .m3_wgrnt(g_fp[3]),
    .wbusy(bz_fp), .grant_idx(gi_fp), .timeout_err(to_fp)
  );

  function automatic int enc(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--)
      if (g[i]) r = i;
    return r;
  endfunction

  function automatic string kname(input int k);
    if (k == K_GRANT) return "GRANT";
    if (k == K_DROP) return "DROP";
    return "TIMEOUT";
  endfunction

  task automatic check_ev(input int d, input int kind, input int idx);
    ev_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_event dut=%0d got %s idx=%0d cyc=%0d, required none", d, kname(kind), idx, cyc);
    end else begin
      e = expq.pop_front();
      if (e.dut != d || e.kind != kind || e.idx != idx || e.cyc != cyc) begin
        fails++;
        $display("[TB] FAIL event dut=%0d got %s idx=%0d cyc=%0d, required dut=%0d %s idx=%0d cyc=%0d",
                 d, kname(kind), idx, cyc, e.dut, kname(e.kind), e.idx, e.cyc);
      end else begin
        $display("[TB] ok dut=%0d %s idx=%0d cyc=%0d", d, kname(kind), idx, cyc);
      end
    end
  endtask

  task automatic mon_dut(input int d, input logic [3:0] g, input logic bz, input logic [1:0] gi,
                         input logic to, input logic [3:0] pg);
    tests++;
    if (!$onehot0(g) || bz != (|g)) begin
      fails++;
      $display("[TB] FAIL invariant dut=%0d grants=%b wbusy=%b, required onehot0 and wbusy=%b", d, g, bz, |g);
    end
    if (areset) begin
      tests++;
      if ({g, bz, gi, to} != 8'h00) begin
        fails++;
        $display("[TB] FAIL reset_state dut=%0d grants=%b wbusy=%b idx=%0d to=%b, required all 0", d, g, bz, gi, to);
      end
    end
    if (to) check_ev(d, K_TO, int'(gi));
    if (pg != 4'b0 && g == 4'b0) check_ev(d, K_DROP, enc(pg));
    if (pg == 4'b0 && g != 4'b0) begin
      check_ev(d, K_GRANT, enc(g));
      tests++;
      if (int'(gi) != enc(g)) begin
        fails++;
        $display("[TB] FAIL grant_idx dut=%0d got %0d, required %0d", d, gi, enc(g));
      end
    end
  endtask

  always @(negedge aclk) begin
    mon_dut(0, g_rr, bz_rr, gi_rr, to_rr, pg_rr);
    mon_dut(1, g_fp, bz_fp, gi_fp, to_fp, pg_fp);
    pg_rr = g_rr;
    pg_fp = g_fp;
    if (done) begin
      tests++;
      if (expq.size() != 0) begin
        fails++;
        $display("[TB] FAIL pending_events got %0d left, required 0 (next %s idx=%0d cyc=%0d)",
                 expq.size(), kname(expq[0].kind), expq[0].idx, expq[0].cyc);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input int d, input int kind, input int idx, input int c);
    ev_t e;
    e.dut = d; e.kind = kind; e.idx = idx; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic clear_req(input int d);
    if (d == 0) req_rr = 4'b0;
    else req_fp = 4'b0;
  endtask

  // Called in the first granted cycle: AW and WLAST together, then B; nxt<0 ends the run.
  task automatic single_beat(input int d, input int idx, input int nxt);
    awv = 1; awr = 1; wv = 1; wr = 1; wl = 1;
    tick;
    awv = 0; awr = 0; wv = 0; wr = 0; wl = 0;
    bv = 1; br = 1;
    push(d, K_DROP, idx, cyc + 1);
    if (nxt >= 0) push(d, K_GRANT, nxt, cyc + 2);
    else clear_req(d);
    tick;
    bv = 0; br = 0;
    tick;
  endtask

  initial begin
    int g;
    repeat (3) tick;
    areset = 0;
    tick;

    // m2 alone, AW then 4-beat burst then B
    req_rr = 4'b0100;
    push(0, K_GRANT, 2, cyc + 1);
    tick;
    req_rr = 4'b0000;
    awv = 1; awr = 1;
    tick;
    awv = 0; awr = 0; wv = 1; wr = 1;
    for (int b = 0; b < 4; b++) begin
      wl = (b == 3);
      tick;
    end
    wv = 0; wr = 0; wl = 0;
    bv = 1; br = 1;
    push(0, K_DROP, 2, cyc + 1);
    tick;
    bv = 0; br = 0;
    repeat (3) tick;

    // Fresh reset so the rotation starts at m0, then all four requesting
    areset = 1;
    tick;
    areset = 0;
    tick;
    req_rr = 4'b1111;
    push(0, K_GRANT, 0, cyc + 1);
    tick;
    for (int k = 0; k < 8; k++)
      single_beat(0, k % 4, (k < 7) ? (k + 1) % 4 : -1);
    repeat (2) tick;

    // Fixed priority: m1 and m3 requesting, m1 must always win
    req_fp = 4'b1010;
    push(1, K_GRANT, 1, cyc + 1);
    tick;
    for (int k = 0; k < 3; k++)
      single_beat(1, 1, (k < 2) ? 1 : -1);
    repeat (2) tick;

    // W before AW: WLAST at t, AW at t+3, B at t+5, drop at t+6
    req_rr = 4'b0010;
    push(0, K_GRANT, 1, cyc + 1);
    tick;
    req_rr = 4'b0000;
    g = cyc;
    wv = 1; wr = 1; wl = 1;
    tick;
    wv = 0; wr = 0; wl = 0;
    repeat (2) tick;
    awv = 1; awr = 1;
    tick;
    awv = 0; awr = 0;
    tick;
    bv = 1; br = 1;
    push(0, K_DROP, 1, g + 6);
    tick;
    bv = 0; br = 0;
    repeat (2) tick;

    // Watchdog: m0 granted, slave silent; m1 waits and wins after the timeout
    req_rr = 4'b0011;
    push(0, K_GRANT, 0, cyc + 1);
    tick;
    g = cyc;
    push(0, K_TO, 0, g + 16);
    push(0, K_DROP, 0, g + 17);
    push(0, K_GRANT, 1, g + 18);
    repeat (18) tick;
    single_beat(0, 1, -1);
    repeat (2) tick;

    // Reset mid-burst with m3 granted, then m0 and m3 requesting
    req_rr = 4'b1000;
    push(0, K_GRANT, 3, cyc + 1);
    tick;
    req_rr = 4'b0000;
    awv = 1; awr = 1;
    tick;
    awv = 0; awr = 0; wv = 1; wr = 1;
    repeat (2) tick;
    push(0, K_DROP, 3, cyc);
    areset = 1;
    wv = 0; wr = 0;
    tick;
    areset = 0;
    req_rr = 4'b1001;
    push(0, K_GRANT, 0, cyc + 1);
    tick;
    single_beat(0, 0, -1);
    repeat (4) tick;

    done = 1;
    repeat (5) tick;
    $display("[TB] FAIL monitor_stall got no summary, required summary after done");
    $fatal(1, "monitor did not finish");
  end

endmodule
